// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with runtime baud divisor, 2-of-3 voting,
// configurable width/parity/stop bits and a valid/ready output with overrun detection.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] baud_div,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int OW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_S0   = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] OS_S1   = OW'(OVERSAMPLE / 2);
    localparam logic [OW-1:0] OS_S2   = OW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic [DIV_WIDTH-1:0]   div_cnt;
    logic [OW-1:0]          os_cnt;
    logic [BW-1:0]          bit_cnt;
    logic                   stop_cnt;
    logic                   s0, s1;
    logic [DATA_BITS-1:0]   shift;
    logic                   par_bad, frm_bad;
    logic                   tick, mid, wrap, maj, exp_par, deliver, drop;

    assign rx_s    = sync[SYNC_STAGES-1];
    // >= rather than == so a divisor lowered mid-frame cannot strand the counter
    assign tick    = (state != S_IDLE) && (div_cnt >= baud_div);
    assign mid     = tick && (os_cnt == OS_S2);
    assign wrap    = tick && (os_cnt == OS_LAST);
    assign maj     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign exp_par = (PARITY == 1) ? ~^shift : ^shift;
    assign deliver = (state == S_STOP) && mid && (stop_cnt == STOP_LAST);
    assign drop    = rx_valid && !rx_ready;
    assign busy    = state != S_IDLE;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset)
            sync <= '1;
        else
            sync <= {sync[SYNC_STAGES-2:0], rx};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!rx_s) state_nxt = S_START;
            S_START:  if (mid && maj) state_nxt = S_IDLE;
                      else if (wrap) state_nxt = S_DATA;
            S_DATA:   if (wrap && bit_cnt == BIT_LAST) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (wrap) state_nxt = S_STOP;
            S_STOP:   if (deliver) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            os_cnt      <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            s0          <= 1'b1;
            s1          <= 1'b1;
            shift       <= '0;
            par_bad     <= 1'b0;
            frm_bad     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= (state == S_IDLE || tick) ? '0 : div_cnt + 1'b1;
            os_cnt   <= (state == S_IDLE) ? '0 : wrap ? '0 : tick ? os_cnt + 1'b1 : os_cnt;
            bit_cnt  <= (state == S_IDLE) ? '0 : (state == S_DATA && wrap) ? bit_cnt + 1'b1 : bit_cnt;
            stop_cnt <= (state == S_IDLE) ? 1'b0 : (state == S_STOP && wrap) ? 1'b1 : stop_cnt;
            if (tick && os_cnt == OS_S0)
                s0 <= rx_s;
            if (tick && os_cnt == OS_S1)
                s1 <= rx_s;
            if (state == S_DATA && mid)
                shift <= {maj, shift[DATA_BITS-1:1]};
            par_bad     <= (state == S_IDLE) ? 1'b0 : (state == S_PARITY && mid) ? (maj != exp_par) : par_bad;
            frm_bad     <= (state == S_IDLE) ? 1'b0 : (state == S_STOP && mid && !maj) ? 1'b1 : frm_bad;
            overrun_err <= deliver && drop;
            if (deliver && !drop) begin
                rx_data    <= shift;
                parity_err <= par_bad;
                frame_err  <= frm_bad | ~maj;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed checks of 8N1 and 8E1 receivers at baud_div=3, 16x oversampling.
module tb_uart_rx_param;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] baud_div = 16'd3;
    logic        rx_a = 1'b1, rx_b = 1'b1, rdy_a = 1'b1, rdy_b = 1'b1;
    logic [7:0]  data_a, data_b;
    logic        val_a, val_b, perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b, busy_a, busy_b;
    int          n_chk = 0, n_fail = 0;
    int          vcnt_a = 0, ocnt_a = 0, vcnt_b = 0;
    logic [7:0]  cap_a = 8'h00, cap_b = 8'h00;
    logic        cap_pa = 1'b0, cap_fa = 1'b0, cap_pb = 1'b0;

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .DIV_WIDTH(16), .SYNC_STAGES(2)) dut_a (
        .sys_clk(clk), .reset(reset), .rx(rx_a), .baud_div(baud_div), .rx_data(data_a), .rx_valid(val_a),
        .rx_ready(rdy_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(ovr_a), .busy(busy_a));

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1), .DIV_WIDTH(16), .SYNC_STAGES(2)) dut_b (
        .sys_clk(clk), .reset(reset), .rx(rx_b), .baud_div(baud_div), .rx_data(data_b), .rx_valid(val_b),
        .rx_ready(rdy_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun_err(ovr_b), .busy(busy_b));

    // Records every valid cycle and overrun pulse, sampled just after each rising edge
    always @(posedge clk) begin
        #2;
        if (val_a) begin
            vcnt_a++;
            cap_a  = data_a;
            cap_pa = perr_a;
            cap_fa = ferr_a;
        end
        if (ovr_a)
            ocnt_a++;
        if (val_b) begin
            vcnt_b++;
            cap_b  = data_b;
            cap_pb = perr_b;
        end
    end

    task automatic hold(input bit sel, input logic v, input int n);
        if (sel)
            rx_b = v;
        else
            rx_a = v;
        repeat (n) @(negedge clk);
    endtask

    // 64 cycles per bit; gbit selects a data bit that gets a 4-cycle inversion at its centre
    task automatic send(input bit sel, input logic [7:0] d, input bit has_par, input logic pbit,
                        input logic sbit, input int gbit, input int gap);
        hold(sel, 1'b0, 64);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                hold(sel, d[i], 36);
                hold(sel, ~d[i], 4);
                hold(sel, d[i], 24);
            end else begin
                hold(sel, d[i], 64);
            end
        end
        if (has_par)
            hold(sel, pbit, 64);
        hold(sel, sbit, 64);
        hold(sel, 1'b1, gap);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if ({data_a, val_a, perr_a, ferr_a, ovr_a, busy_a} !== 13'h0) begin n_fail++; $display("FAIL reset_a: got %h required 0", {data_a, val_a, perr_a, ferr_a, ovr_a, busy_a}); end
        n_chk++; if ({data_b, val_b, perr_b, ferr_b, ovr_b, busy_b} !== 13'h0) begin n_fail++; $display("FAIL reset_b: got %h required 0", {data_b, val_b, perr_b, ferr_b, ovr_b, busy_b}); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy %b required 0", busy_a); end
    endtask

    task automatic test_basic();
        int bv = vcnt_a, bo = ocnt_a;
        rdy_a = 1'b1;
        send(0, 8'hA5, 0, 0, 1, -1, 64);
        n_chk++; if (vcnt_a - bv != 1) begin n_fail++; $display("FAIL basic_pulse: valid cycles %0d required 1", vcnt_a - bv); end
        n_chk++; if (cap_a !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h required a5", cap_a); end
        n_chk++; if ({cap_pa, cap_fa} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got %b required 00", {cap_pa, cap_fa}); end
        n_chk++; if (ocnt_a != bo) begin n_fail++; $display("FAIL basic_ovr: pulses %0d required 0", ocnt_a - bo); end
        n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b required 0", busy_a); end
    endtask

    task automatic test_glitch();
        int bv = vcnt_a;
        hold(0, 1'b0, 20);
        n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_hi: got %b required 1", busy_a); end
        hold(0, 1'b1, 100);
        n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_lo: got %b required 0", busy_a); end
        n_chk++; if (vcnt_a != bv) begin n_fail++; $display("FAIL glitch_valid: valid cycles %0d required 0", vcnt_a - bv); end
    endtask

    task automatic test_parity();
        int bv = vcnt_b;
        send(1, 8'h5A, 1, 1, 1, -1, 64);
        n_chk++; if (vcnt_b - bv != 1) begin n_fail++; $display("FAIL par_bad_pulse: valid cycles %0d required 1", vcnt_b - bv); end
        n_chk++; if (cap_b !== 8'h5A) begin n_fail++; $display("FAIL par_bad_data: got %h required 5a", cap_b); end
        n_chk++; if (cap_pb !== 1'b1) begin n_fail++; $display("FAIL par_bad_flag: got %b required 1", cap_pb); end
        bv = vcnt_b;
        send(1, 8'h5A, 1, 0, 1, -1, 64);
        n_chk++; if (vcnt_b - bv != 1) begin n_fail++; $display("FAIL par_ok_pulse: valid cycles %0d required 1", vcnt_b - bv); end
        n_chk++; if (cap_pb !== 1'b0) begin n_fail++; $display("FAIL par_ok_flag: got %b required 0", cap_pb); end
    endtask

    task automatic test_frame_err();
        int bv = vcnt_a;
        send(0, 8'h3C, 0, 0, 0, -1, 128);
        n_chk++; if (vcnt_a - bv != 1) begin n_fail++; $display("FAIL ferr_pulse: valid cycles %0d required 1", vcnt_a - bv); end
        n_chk++; if (cap_a !== 8'h3C) begin n_fail++; $display("FAIL ferr_data: got %h required 3c", cap_a); end
        n_chk++; if (cap_fa !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b required 1", cap_fa); end
        bv = vcnt_a;
        send(0, 8'h11, 0, 0, 1, -1, 64);
        n_chk++; if (vcnt_a - bv != 1) begin n_fail++; $display("FAIL ferr_next_pulse: valid cycles %0d required 1", vcnt_a - bv); end
        n_chk++; if ({cap_a, cap_fa} !== {8'h11, 1'b0}) begin n_fail++; $display("FAIL ferr_next: got %h/%b required 11/0", cap_a, cap_fa); end
    endtask

    task automatic test_back_to_back();
        int bo = ocnt_a;
        rdy_a = 1'b0;
        send(0, 8'h01, 0, 0, 1, -1, 0);
        send(0, 8'h02, 0, 0, 1, -1, 64);
        n_chk++; if (val_a !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b required 1", val_a); end
        n_chk++; if (data_a !== 8'h01) begin n_fail++; $display("FAIL ovr_data: got %h required 01", data_a); end
        n_chk++; if (ocnt_a - bo != 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d required 1", ocnt_a - bo); end
        rdy_a = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (val_a !== 1'b0) begin n_fail++; $display("FAIL ovr_accept: valid %b required 0", val_a); end
    endtask

    task automatic test_majority();
        int bv = vcnt_a;
        send(0, 8'hFF, 0, 0, 1, 3, 64);
        n_chk++; if (vcnt_a - bv != 1) begin n_fail++; $display("FAIL maj_pulse: valid cycles %0d required 1", vcnt_a - bv); end
        n_chk++; if ({cap_a, cap_fa} !== {8'hFF, 1'b0}) begin n_fail++; $display("FAIL maj_data: got %h/%b required ff/0", cap_a, cap_fa); end
    endtask

    task automatic test_reset_mid();
        int bv;
        hold(0, 1'b0, 64);
        hold(0, 1'b0, 64);
        hold(0, 1'b1, 64);
        hold(0, 1'b1, 64);
        hold(0, 1'b0, 20);
        n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL rmid_busy: got %b required 1", busy_a); end
        reset = 1'b1;
        rx_a = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if ({data_a, val_a, perr_a, ferr_a, ovr_a, busy_a} !== 13'h0) begin n_fail++; $display("FAIL rmid_outputs: got %h required 0", {data_a, val_a, perr_a, ferr_a, ovr_a, busy_a}); end
        reset = 1'b0;
        bv = vcnt_a;
        hold(0, 1'b1, 128);
        n_chk++; if (vcnt_a != bv) begin n_fail++; $display("FAIL rmid_partial: valid cycles %0d required 0", vcnt_a - bv); end
        send(0, 8'h69, 0, 0, 1, -1, 64);
        n_chk++; if (vcnt_a - bv != 1) begin n_fail++; $display("FAIL rmid_next_pulse: valid cycles %0d required 1", vcnt_a - bv); end
        n_chk++; if ({cap_a, cap_pa, cap_fa} !== {8'h69, 2'b00}) begin n_fail++; $display("FAIL rmid_next: got %h/%b%b required 69/00", cap_a, cap_pa, cap_fa); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_frame_err();
        test_back_to_back();
        test_majority();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
